// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO-draining UART transmitter: start, WID data bits LSB-first, optional even parity, stop.
module fifo_uart_tx #(
  parameter int WID          = 16,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en_i,
  input  logic           fifo_empty_i,
  input  logic [WID-1:0] fifo_rdata_i,
  output logic           fifo_rd_o,
  output logic           tx_o,
  output logic           busy_o,
  output logic           frame_done_o,
  output logic [15:0]    word_cnt_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (WID > 1) ? $clog2(WID) : 1;
  localparam logic [CW-1:0] LAST_BAUD = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(WID - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_baud;
  logic [IW-1:0]   r_bit_idx;
  logic [WID-1:0]  r_shreg;
  logic            r_par;
  logic            r_tx;
  logic            r_busy;
  logic [15:0]     r_word_cnt;
  logic            w_bit_end;
  logic            w_stop_end;
  logic            w_launch;
  logic            w_tx_next;

  assign w_bit_end  = (r_baud == LAST_BAUD);
  assign w_stop_end = (r_state == S_STOP) && w_bit_end;
  // Gated by reset so no read strobe escapes while the block is held in reset.
  assign w_launch   = rst && en_i && !fifo_empty_i && ((r_state == S_IDLE) || w_stop_end);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_launch) w_next = S_START;
      S_START:  if (w_bit_end) w_next = S_DATA;
      S_DATA:   if (w_bit_end && (r_bit_idx == LAST_BIT))
                  w_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (w_bit_end) w_next = S_STOP;
      S_STOP:   if (w_bit_end) w_next = w_launch ? S_START : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_rd_o    = w_launch;
    frame_done_o = w_stop_end;
    w_tx_next    = r_tx;
    if (w_launch) begin
      w_tx_next = 1'b0;
    end else if (w_bit_end) begin
      case (r_state)
        S_START:  w_tx_next = r_shreg[0];
        // r_shreg shifts on this same edge, so the next bit is still at index 1.
        S_DATA:   w_tx_next = (r_bit_idx == LAST_BIT) ? ((PARITY_EN != 0) ? r_par : 1'b1) : r_shreg[1];
        S_PARITY: w_tx_next = 1'b1;
        S_STOP:   w_tx_next = 1'b1;
        default:  w_tx_next = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_shreg    <= '0;
      r_par      <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      r_tx   <= w_tx_next;
      r_busy <= (w_next != S_IDLE);
      if (w_stop_end) r_word_cnt <= r_word_cnt + 16'd1;
      if (w_launch) begin
        r_shreg <= fifo_rdata_i;
        r_par   <= ^fifo_rdata_i;
        r_baud  <= '0;
      end else if (r_state != S_IDLE) begin
        r_baud <= w_bit_end ? '0 : r_baud + CW'(1);
        if (w_bit_end && (r_state == S_START)) begin
          r_bit_idx <= '0;
        end else if (w_bit_end && (r_state == S_DATA)) begin
          r_shreg   <= r_shreg >> 1;
          r_bit_idx <= r_bit_idx + IW'(1);
        end
      end
    end
  end

  assign tx_o       = r_tx;
  assign busy_o     = r_busy;
  assign word_cnt_o = r_word_cnt;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench: queue FIFO plus frame-waveform reference model for two configurations.
module tb_fifo_uart_tx;
  logic clk = 1'b0;
  logic rst, en, en2, empty, empty2;
  logic [15:0] rdata, rdata2, cnt, cnt2;
  logic rd, rd2, tx, tx2, busy, busy2, done, done2;

  always #5 clk = ~clk;

  fifo_uart_tx dut (
    .clk(clk), .rst(rst), .en_i(en), .fifo_empty_i(empty), .fifo_rdata_i(rdata),
    .fifo_rd_o(rd), .tx_o(tx), .busy_o(busy), .frame_done_o(done), .word_cnt_o(cnt)
  );

  fifo_uart_tx #(.WID(16), .CLKS_PER_BIT(2), .PARITY_EN(0)) dut2 (
    .clk(clk), .rst(rst), .en_i(en2), .fifo_empty_i(empty2), .fifo_rdata_i(rdata2),
    .fifo_rd_o(rd2), .tx_o(tx2), .busy_o(busy2), .frame_done_o(done2), .word_cnt_o(cnt2)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int rd_cnt = 0, done2_cnt = 0, start_cyc = 0, start2 = 0, last_len = 0, last_len2 = 0, pushed = 0;
  logic smp_rd;
  logic [15:0] fq[$], fq2[$];
  logic el[$], el2[$];
  logic par_seen[$];
  int starts[$];
  logic [15:0] mcnt = 16'd0, mcnt2 = 16'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Line level of frame bit idx: 0 start, 1..16 data LSB first, 17 parity (if enabled), then stop.
  function automatic logic frame_bit(input logic [15:0] w, input int idx, input int pen);
    if (idx == 0) return 1'b0;
    if (idx <= 16) return w[idx-1];
    if (pen != 0 && idx == 17) return ($countones(w) % 2) == 1;
    return 1'b1;
  endfunction

  task automatic tick();
    logic e_tx, e_busy, e_done, e_rd, junk;
    logic [15:0] w;
    empty  = (fq.size() == 0);
    rdata  = (fq.size() != 0) ? fq[0] : 16'h0;
    empty2 = (fq2.size() == 0);
    rdata2 = (fq2.size() != 0) ? fq2[0] : 16'h0;
    #1;
    cyc++;
    smp_rd = rd;
    e_busy = (el.size() != 0);
    e_done = (el.size() == 1);
    e_tx   = (el.size() != 0) ? el[0] : 1'b1;
    e_rd   = rst && en && (fq.size() != 0) && (el.size() <= 1);
    check_eq("tx", tx, e_tx);
    check_eq("busy", busy, e_busy);
    check_eq("frame_done", done, e_done);
    check_eq("fifo_rd", rd, e_rd);
    check_eq("word_cnt", cnt, mcnt);
    if (el.size() != 0) junk = el.pop_front();
    if (e_done) mcnt = mcnt + 16'd1;
    if (e_rd) begin
      w = fq.pop_front();
      for (int b = 0; b < 19; b++) for (int c = 0; c < 4; c++) el.push_back(frame_bit(w, b, 1));
    end
    if (busy && (cyc - start_cyc == 69)) par_seen.push_back(tx);
    if (done) last_len = cyc - start_cyc + 1;
    if (rd) begin rd_cnt++; start_cyc = cyc + 1; starts.push_back(start_cyc); end

    e_busy = (el2.size() != 0);
    e_done = (el2.size() == 1);
    e_tx   = (el2.size() != 0) ? el2[0] : 1'b1;
    e_rd   = rst && en2 && (fq2.size() != 0) && (el2.size() <= 1);
    check_eq("tx2", tx2, e_tx);
    check_eq("busy2", busy2, e_busy);
    check_eq("frame_done2", done2, e_done);
    check_eq("fifo_rd2", rd2, e_rd);
    check_eq("word_cnt2", cnt2, mcnt2);
    if (el2.size() != 0) junk = el2.pop_front();
    if (e_done) mcnt2 = mcnt2 + 16'd1;
    if (e_rd) begin
      w = fq2.pop_front();
      for (int b = 0; b < 18; b++) for (int c = 0; c < 2; c++) el2.push_back(frame_bit(w, b, 0));
    end
    if (done2) begin done2_cnt++; last_len2 = cyc - start2 + 1; end
    if (rd2) start2 = cyc + 1;
    @(negedge clk);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (n < limit && ((en && fq.size() != 0) || (en2 && fq2.size() != 0) ||
                         el.size() != 0 || el2.size() != 0)) begin
      tick();
      n++;
    end
    check_eq("drain_in_time", (n < limit), 1);
  endtask

  initial begin
    int base, n;
    rst = 1'b0; en = 1'b1; en2 = 1'b0;
    @(negedge clk);
    repeat (3) tick();
    rst = 1'b1;

    repeat (200) tick();
    check_eq("idle_no_read", rd_cnt, 0);
    check_eq("idle_cnt", cnt, 0);
    check_eq("idle_tx", tx, 1);

    base = rd_cnt; par_seen.delete();
    fq.push_back(16'hA5C3);
    drain(300);
    check_eq("single_reads", rd_cnt - base, 1);
    check_eq("single_len", last_len, 76);
    check_eq("single_cnt", cnt, 1);
    check_eq("single_par", (par_seen.size() == 1) ? par_seen[0] : 1'bx, 0);

    en = 1'b0; base = rd_cnt; par_seen.delete(); starts.delete();
    fq.push_back(16'h0001); fq.push_back(16'hFFFF); fq.push_back(16'h8000);
    tick();
    en = 1'b1;
    drain(400);
    check_eq("burst_reads", rd_cnt - base, 3);
    check_eq("burst_gap01", (starts.size() == 3) ? starts[1] - starts[0] : 0, 76);
    check_eq("burst_gap12", (starts.size() == 3) ? starts[2] - starts[1] : 0, 76);
    check_eq("burst_pars", (par_seen.size() == 3) ? {par_seen[0], par_seen[1], par_seen[2]} : 3'bxxx, 3'b101);
    check_eq("burst_cnt", cnt, 4);

    base = rd_cnt;
    fq.push_back(16'h1234); fq.push_back(16'h0F0F);
    repeat (30) tick();
    en = 1'b0;
    drain(200);
    repeat (10) tick();
    check_eq("en_drop_reads", rd_cnt - base, 1);
    check_eq("en_drop_cnt", cnt, 5);
    en = 1'b1;
    tick();
    check_eq("relaunch", smp_rd, 1);
    drain(200);
    check_eq("relaunch_len", last_len, 76);

    base = rd_cnt;
    fq.push_back(16'h5A5A); fq.push_back(16'hC3C3);
    n = 0;
    tick();
    while (n < 100 && !(busy && cyc - start_cyc == 25)) begin tick(); n++; end
    check_eq("reached_bit5", (n < 100), 1);
    rst = 1'b0;
    #1;
    check_eq("rst_tx", tx, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_cnt", cnt, 0);
    el.delete(); el2.delete(); mcnt = 16'd0; mcnt2 = 16'd0;
    repeat (3) tick();
    rst = 1'b1;
    drain(200);
    check_eq("post_rst_reads", rd_cnt - base, 2);
    check_eq("post_rst_len", last_len, 76);
    check_eq("post_rst_cnt", cnt, 1);

    base = rd_cnt; pushed = 0;
    repeat (1500) begin
      if ($urandom_range(0, 24) == 0 && fq.size() < 6) begin fq.push_back(16'($urandom)); pushed++; end
      if ($urandom_range(0, 59) == 0) en = ~en;
      tick();
    end
    en = 1'b1;
    drain(800);
    check_eq("rand_reads", rd_cnt - base, pushed);
    check_eq("rand_cnt", cnt, 16'(1 + pushed));

    en = 1'b0; en2 = 1'b1;
    fq2.push_back(16'h00FF);
    drain(200);
    repeat (5) tick();
    check_eq("np_len", last_len2, 36);
    check_eq("np_done_pulses", done2_cnt, 1);
    check_eq("np_cnt", cnt2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
